// File: rtl/mmcm_ps_pkg.sv
// Shared constants for the MMCM phase-shift responder and the initiator benches that drive it.
package mmcm_ps_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned DEFAULT_LATENCY          = 12;
  localparam int unsigned DEFAULT_STEPS_PER_PERIOD = 448;

endpackage

// File: rtl/mmcm_ps_phase_acc.sv
// Phase position tracker: modulo phase register plus a saturating signed step offset.
module mmcm_ps_phase_acc #(
  parameter int unsigned STEPS_PER_PERIOD = 448,
  parameter int unsigned OFFSET_W         = 16
) (
  input  logic                                clk_usb,
  input  logic                                reset,
  input  logic                                step_en,
  input  logic                                step_inc,
  output logic [$clog2(STEPS_PER_PERIOD)-1:0] phase_mod,
  output logic signed [OFFSET_W-1:0]          offset
);

  localparam int unsigned PHASE_W = $clog2(STEPS_PER_PERIOD);

  localparam logic [PHASE_W-1:0]         PHASE_MAX = PHASE_W'(STEPS_PER_PERIOD - 1);
  localparam logic signed [OFFSET_W-1:0] OFF_MAX   = {1'b0, {(OFFSET_W-1){1'b1}}};
  localparam logic signed [OFFSET_W-1:0] OFF_MIN   = {1'b1, {(OFFSET_W-1){1'b0}}};

  logic [PHASE_W-1:0]         phase_q, phase_d;
  logic signed [OFFSET_W-1:0] offset_q, offset_d;

  // Phase always wraps; only the offset saturates.
  always_comb begin
    phase_d  = phase_q;
    offset_d = offset_q;
    if (step_en) begin
      if (step_inc) begin
        phase_d  = (phase_q == PHASE_MAX) ? '0 : phase_q + 1'b1;
        offset_d = (offset_q == OFF_MAX) ? offset_q : offset_q + 1'b1;
      end else begin
        phase_d  = (phase_q == '0) ? PHASE_MAX : phase_q - 1'b1;
        offset_d = (offset_q == OFF_MIN) ? offset_q : offset_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      phase_q  <= '0;
      offset_q <= '0;
    end else begin
      phase_q  <= phase_d;
      offset_q <= offset_d;
    end
  end

  assign phase_mod = phase_q;
  assign offset    = offset_q;

endmodule

// File: rtl/mmcm_ps_responder.sv
// MMCM dynamic phase-shift responder (PSEN/PSINCDEC/PSDONE, MMCM side).
// Define MMCM_PS_RESPONDER_STATS_EN to add saturating increment/decrement completion counters.
module mmcm_ps_responder
  import mmcm_ps_pkg::*;
#(
  parameter int unsigned LATENCY          = DEFAULT_LATENCY,
  parameter int unsigned STEPS_PER_PERIOD = DEFAULT_STEPS_PER_PERIOD,
  parameter int unsigned OFFSET_W         = 16
) (
  input  logic                                clk_usb,
  input  logic                                reset,
  input  logic                                I_psen,
  input  logic                                I_psincdec,
  input  logic                                I_clear_err,
  output logic                                O_psdone,
  output logic                                O_busy,
  output logic [$clog2(STEPS_PER_PERIOD)-1:0] O_phase_mod,
  output logic signed [OFFSET_W-1:0]          O_offset,
`ifdef MMCM_PS_RESPONDER_STATS_EN
  output logic [15:0]                         O_inc_count,
  output logic [15:0]                         O_dec_count,
`endif
  output logic                                O_overrun
);

  // Counter only ever holds LATENCY-2 down to 0.
  localparam int unsigned CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             incdec_q, incdec_d;
  logic             overrun_q, overrun_d;
  logic             step_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    incdec_d  = incdec_q;
    overrun_d = overrun_q;
    step_done = 1'b0;
    if (I_clear_err) begin
      overrun_d = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (I_psen) begin
          incdec_d = I_psincdec;
          cnt_d    = CNT_W'(LATENCY - 2);
          state_d  = ST_COUNT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
        // A request while a step is in flight is dropped and flagged; set beats clear.
        if (I_psen) begin
          overrun_d = 1'b1;
        end
        if (cnt_q == '0) begin
          state_d   = ST_DONE;
          step_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_usb) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      incdec_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      incdec_q  <= incdec_d;
      overrun_q <= overrun_d;
    end
  end

  // The accumulator steps on the edge entering DONE so its value lands with psdone.
  mmcm_ps_phase_acc #(
    .STEPS_PER_PERIOD (STEPS_PER_PERIOD),
    .OFFSET_W         (OFFSET_W)
  ) u_phase_acc (
    .clk_usb   (clk_usb),
    .reset     (reset),
    .step_en   (step_done),
    .step_inc  (incdec_q),
    .phase_mod (O_phase_mod),
    .offset    (O_offset)
  );

  assign O_psdone  = (state_q == ST_DONE);
  assign O_busy    = (state_q == ST_COUNT);
  assign O_overrun = overrun_q;

`ifdef MMCM_PS_RESPONDER_STATS_EN
  logic [15:0] inc_count_q, dec_count_q;

  always_ff @(posedge clk_usb) begin
    if (reset || I_clear_err) begin
      inc_count_q <= '0;
      dec_count_q <= '0;
    end else if (step_done) begin
      if (incdec_q && (inc_count_q != 16'hFFFF)) begin
        inc_count_q <= inc_count_q + 16'd1;
      end
      if (!incdec_q && (dec_count_q != 16'hFFFF)) begin
        dec_count_q <= dec_count_q + 16'd1;
      end
    end
  end

  assign O_inc_count = inc_count_q;
  assign O_dec_count = dec_count_q;
`endif

endmodule

// File: tb/tb_mmcm_ps_responder.sv
// Self-checking bench: a 16-bit-offset and a 4-bit-offset responder share stimulus.
module tb_mmcm_ps_responder;

  localparam int L = 12;
  localparam int S = 448;

  logic clk_usb = 1'b0;
  logic reset = 1'b1;
  logic psen = 1'b0;
  logic incdec = 1'b0;
  logic clr = 1'b0;

  logic              psdone16, busy16, ovr16;
  logic              psdone4, busy4, ovr4;
  logic [8:0]        ph16, ph4;
  logic signed [15:0] off16;
  logic signed [3:0]  off4;

  always #5 clk_usb = ~clk_usb;

  mmcm_ps_responder #(.LATENCY(L), .STEPS_PER_PERIOD(S), .OFFSET_W(16)) dut16 (
    .clk_usb     (clk_usb),
    .reset       (reset),
    .I_psen      (psen),
    .I_psincdec  (incdec),
    .I_clear_err (clr),
    .O_psdone    (psdone16),
    .O_busy      (busy16),
    .O_phase_mod (ph16),
    .O_offset    (off16),
    .O_overrun   (ovr16)
  );

  mmcm_ps_responder #(.LATENCY(L), .STEPS_PER_PERIOD(S), .OFFSET_W(4)) dut4 (
    .clk_usb     (clk_usb),
    .reset       (reset),
    .I_psen      (psen),
    .I_psincdec  (incdec),
    .I_clear_err (clr),
    .O_psdone    (psdone4),
    .O_busy      (busy4),
    .O_phase_mod (ph4),
    .O_offset    (off4),
    .O_overrun   (ovr4)
  );

  // Reference model: a step accepted in cycle A completes in cycle A+L.
  int m_acc = -1000;
  int m_dir = 0;
  int m_phase = 0;
  int m_off16 = 0;
  int m_off4 = 0;
  int m_ovr = 0;
  int m_cyc = 0;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int m_psdone();
    return (m_cyc == m_acc + L) ? 1 : 0;
  endfunction

  function automatic int m_busy();
    return (m_acc < m_cyc && m_cyc < m_acc + L) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", nm, m_cyc, act, exp);
    end
  endtask

  task automatic apply_step(input int dir);
    if (dir != 0) begin
      m_phase = (m_phase + 1) % S;
      m_off16 = (m_off16 < 32767) ? m_off16 + 1 : m_off16;
      m_off4  = (m_off4 < 7) ? m_off4 + 1 : m_off4;
    end else begin
      m_phase = (m_phase + S - 1) % S;
      m_off16 = (m_off16 > -32768) ? m_off16 - 1 : m_off16;
      m_off4  = (m_off4 > -8) ? m_off4 - 1 : m_off4;
    end
  endtask

  // Drive one cycle's inputs, advance the model over the edge, check on the next negedge.
  task automatic tick(input logic p, input logic i, input logic c, input logic r);
    int b;
    psen = p; incdec = i; clr = c; reset = r;
    @(posedge clk_usb);
    if (r) begin
      m_acc = -1000; m_phase = 0; m_off16 = 0; m_off4 = 0; m_ovr = 0;
    end else begin
      b = m_busy();
      if (m_cyc + 1 == m_acc + L) apply_step(m_dir);
      if (p && b != 0) m_ovr = 1;
      else if (c) m_ovr = 0;
      if (p && b == 0) begin
        m_acc = m_cyc;
        m_dir = i ? 1 : 0;
      end
    end
    m_cyc++;
    @(negedge clk_usb);
    chk("psdone16", int'(psdone16), m_psdone());
    chk("busy16", int'(busy16), m_busy());
    chk("phase16", int'(ph16), m_phase);
    chk("offset16", int'(off16), m_off16);
    chk("overrun16", int'(ovr16), m_ovr);
    chk("psdone4", int'(psdone4), m_psdone());
    chk("phase4", int'(ph4), m_phase);
    chk("offset4", int'(off4), m_off4);
  endtask

  // Issue one request and wait (bounded) for its psdone; leaves the bench in the psdone cycle.
  task automatic do_step(input logic i);
    int lat;
    tick(1'b1, i, 1'b0, 1'b0);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (psdone16) begin
        lat = k;
        break;
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("latency", lat, L);
  endtask

  typedef struct {
    logic rst_before;
    logic inc;
    int   exp_phase;
    int   exp_off16;
    int   exp_off4;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cnt;
    int first;

    vecs[0]  = '{1'b1, 1'b1, 1, 1, 1};
    vecs[1]  = '{1'b1, 1'b0, 447, -1, -1};
    vecs[2]  = '{1'b0, 1'b1, 0, 0, 0};
    for (int k = 1; k <= 8; k++) begin
      vecs[2 + k] = '{1'b0, 1'b1, k, k, (k < 7) ? k : 7};
    end
    vecs[11] = '{1'b0, 1'b0, 7, 7, 6};

    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_psdone", int'(psdone16), 0);
    chk("rst_busy", int'(busy16), 0);
    chk("rst_phase", int'(ph16), 0);
    chk("rst_offset", int'(off16), 0);
    chk("rst_overrun", int'(ovr16), 0);

    // Back-to-back: every step after the first is requested in the previous psdone cycle.
    for (int v = 0; v < 12; v++) begin
      if (vecs[v].rst_before) tick(1'b0, 1'b0, 1'b0, 1'b1);
      do_step(vecs[v].inc);
      chk($sformatf("vec%0d_phase", v), int'(ph16), vecs[v].exp_phase);
      chk($sformatf("vec%0d_off16", v), int'(off16), vecs[v].exp_off16);
      chk($sformatf("vec%0d_off4", v), int'(off4), vecs[v].exp_off4);
    end

    // Overrun during COUNT, single completion, then clear.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ovr_set_cyc6", int'(ovr16), 1);
    cnt = 0; first = -1;
    for (int k = 6; k <= 20; k++) begin
      if (psdone16) begin
        cnt++;
        if (first < 0) first = k;
      end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("ovr_psdone_count", cnt, 1);
    chk("ovr_psdone_cycle", first, L);
    chk("ovr_phase", int'(ph16), 1);
    chk("ovr_offset", int'(off16), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovr_cleared", int'(ovr16), 0);

    // Set and clear in the same cycle: set wins.
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ovr_set_wins", int'(ovr16), 1);
    for (int k = 0; k < 15; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation aborts the step.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int k = 7; k <= 20; k++) begin
      if (psdone16) cnt++;
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("abort_psdone_count", cnt, 0);
    chk("abort_phase", int'(ph16), 0);
    chk("abort_offset", int'(off16), 0);
    chk("abort_busy", int'(busy16), 0);

    // Negative saturation on the narrow build while phase keeps wrapping.
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 9; k++) do_step(1'b0);
    chk("negsat_off4", int'(off4), -8);
    chk("negsat_off16", int'(off16), -9);
    chk("negsat_phase4", int'(ph4), 439);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      tick(($urandom_range(0, 3) == 0), logic'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmcm_ps_responder.md
Name: mmcm_ps_responder

Overview:
- Synthesizable responder for the MMCM dynamic phase-shift port: the PSEN/PSINCDEC/PSDONE handshake seen from the MMCM side.
- Used as a drop-in stand-in for the MMCM in simulation and in fabric test builds.
- Tracks the phase position it has been driven to, so the initiating FSM can be checked end-to-end without a real primitive.
- Sits on the clk_usb domain next to the phase-shift initiator.

Parameters:
- LATENCY, 12, cycles from accepted psen to psdone (must be >= 2).
- STEPS_PER_PERIOD, 448, phase steps per output-clock period (modulo for O_phase_mod).
- OFFSET_W, 16, width of the signed cumulative offset.

Ports:
- clk_usb  in  1  clock
- reset  in  1  synchronous, active-high reset
- I_psen  in  1  phase-shift request strobe from the initiator
- I_psincdec  in  1  1 = increment, 0 = decrement; sampled with I_psen
- O_psdone  out  1  one-cycle completion pulse
- O_busy  out  1  high while a step is in flight
- O_phase_mod  out  clog2(STEPS_PER_PERIOD)  current phase, 0..STEPS_PER_PERIOD-1, wraps
- O_offset  out  OFFSET_W signed  cumulative step count, saturating
- O_overrun  out  1  sticky protocol-violation flag
- I_clear_err  in  1  clears O_overrun

Behaviour:
- Reset: reset is synchronous, active-high, on clk_usb. All outputs go to 0; state = IDLE; the latency counter is cleared.
- States: IDLE, COUNT, DONE.
- IDLE: if I_psen = 1, latch I_psincdec, load the counter with LATENCY-2, go to COUNT, O_busy <= 1. Otherwise stay in IDLE.
- COUNT: decrement the counter each cycle; when it reaches 0, go to DONE.
- DONE: O_psdone = 1 for exactly this cycle; O_busy = 0.
  - O_phase_mod and O_offset update in the same cycle (registered, visible with psdone).
  - If I_psen = 1 in this cycle, it is accepted exactly as in IDLE (back-to-back). Otherwise go to IDLE.
- Latency: psen sampled in cycle N gives psdone high in cycle N+LATENCY and no other cycle.
- Phase arithmetic:
  - Increment: O_phase_mod = STEPS_PER_PERIOD-1 wraps to 0.
  - Decrement: O_phase_mod = 0 wraps to STEPS_PER_PERIOD-1.
  - O_offset saturates at +2^(OFFSET_W-1)-1 and -2^(OFFSET_W-1).
  - O_phase_mod keeps wrapping even while O_offset is saturated.
- Overrun: I_psen = 1 while in COUNT is ignored; no state, counter or latched-direction change. O_overrun <= 1.
- Clear: I_clear_err clears O_overrun the next cycle. If an overrun and a clear occur in the same cycle, set wins (O_overrun = 1).
- Reset mid-operation: the in-flight step is aborted, no psdone is issued, and the phase is restored to 0.
- I_psincdec is ignored whenever I_psen = 0.

Optional Feature:
- Macro: MMCM_PS_RESPONDER_STATS_EN.
- With the macro: adds outputs O_inc_count and O_dec_count (16-bit each). They count completed increments and decrements, saturate at 0xFFFF, clear on reset or I_clear_err, and update in the psdone cycle.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mmcm_ps_pkg holds:
  - state encodings (IDLE = 0, COUNT = 1, DONE = 2);
  - default LATENCY = 12 and STEPS_PER_PERIOD = 448 constants, also used by initiator testbenches.
- One natural sub-module: mmcm_ps_phase_acc.
  - Holds the modulo phase register plus the saturating signed offset.
  - Inputs: step enable, direction.
  - Instantiated once in the top.

Test Plan:
- Reset, then psen = 1 with incdec = 1 at cycle 0 -> O_busy = 1 for cycles 1..11; psdone only at cycle 12; O_phase_mod = 1, O_offset = 1.
- From reset, one decrement -> at psdone, O_phase_mod = 447, O_offset = -1. Then one increment -> O_phase_mod = 0, O_offset = 0.
- Step accepted at cycle 0, extra psen at cycle 5 -> O_overrun = 1 from cycle 6; still a single psdone at cycle 12; phase changes by 1 only. Pulse I_clear_err -> O_overrun = 0 next cycle.
- psen asserted in the psdone cycle (cycle 12) -> accepted; second psdone at cycle 24; O_offset = 2.
- Force O_offset to 32767 through 32767 increments (or use a short OFFSET_W = 4 build) and increment once more -> O_offset stays at max; O_phase_mod still advances by 1 mod 448.
- Step accepted at cycle 0, reset at cycle 6 -> no psdone through cycle 20; O_phase_mod = 0, O_offset = 0, O_busy = 0.
